// File: rtl/ultra_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ultra_pkg
// Description : Shared types and 50 MHz timing defaults for the ultrasonic
//               ping scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ultra_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIGGER   = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_PUBLISH   = 3'd4,
        ST_GUARD     = 3'd5
    } state_t;

    localparam int DEF_NUM_SENSORS         = 4;
    localparam int DEF_TRIG_CYCLES         = 500;
    localparam int DEF_CYCLES_PER_CM       = 2900;
    localparam int DEF_ECHO_TIMEOUT_CYCLES = 1_500_000;
    localparam int DEF_GUARD_CYCLES        = 500_000;

    localparam logic [15:0] DIST_TIMEOUT = 16'hFFFF;
    localparam logic [15:0] DIST_MAX     = 16'hFFFE;

    function automatic int sensor_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ultra_echo_sync.sv
`default_nettype none
// ============================================================================
// Module      : ultra_echo_sync
// Description : Per-bit 2-flop synchronizer with rise/fall pulse detection.
// Revision    : 1.0 - initial release
// ============================================================================
module ultra_echo_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/ultra_ping_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ultra_ping_scheduler
// Description : Round-robin HC-SR04 ping sequencer with echo-width to cm
//               conversion and a valid/ready result port.
// Revision    : 1.0 - initial release
// ============================================================================
module ultra_ping_scheduler
    import ultra_pkg::*;
#(
    parameter int NUM_SENSORS         = DEF_NUM_SENSORS,
    parameter int TRIG_CYCLES         = DEF_TRIG_CYCLES,
    parameter int CYCLES_PER_CM       = DEF_CYCLES_PER_CM,
    parameter int ECHO_TIMEOUT_CYCLES = DEF_ECHO_TIMEOUT_CYCLES,
    parameter int GUARD_CYCLES        = DEF_GUARD_CYCLES
) (
    input  logic                           clk,
    input  logic                           reset_l,
    input  logic                           enable,
    input  logic [NUM_SENSORS-1:0]         sensor_mask,
    input  logic [NUM_SENSORS-1:0]         echo,
    output logic [NUM_SENSORS-1:0]         trigger,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic [$clog2(NUM_SENSORS)-1:0] result_sensor,
    output logic [15:0]                    result_dist_cm,
    output logic                           result_timeout,
    output logic                           busy
);

    localparam int IDX_W   = sensor_idx_width(NUM_SENSORS);
    localparam int CNT_MAX = max_int(max_int(TRIG_CYCLES, ECHO_TIMEOUT_CYCLES), GUARD_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int SUB_W   = $clog2(CYCLES_PER_CM + 1);

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [IDX_W-1:0]         sel_q, sel_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SUB_W-1:0]         sub_q, sub_d;
    logic [15:0]              dist_q, dist_d;
    logic [NUM_SENSORS-1:0]   trigger_q, trigger_d;
    logic                     valid_q, valid_d;
    logic [IDX_W-1:0]         rsensor_q, rsensor_d;
    logic [15:0]              rdist_q, rdist_d;
    logic                     rtimeout_q, rtimeout_d;
    logic [NUM_SENSORS-1:0]   echo_rise;
    logic [NUM_SENSORS-1:0]   echo_fall;

    ultra_echo_sync #(.WIDTH(NUM_SENSORS)) u_echo_sync (
        .clk      (clk),
        .reset_l  (reset_l),
        .async_in (echo),
        .rise     (echo_rise),
        .fall     (echo_fall)
    );

    // First set mask bit strictly after p, wrapping back around to p itself.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] p,
                                                  input logic [NUM_SENSORS-1:0] m);
        logic [IDX_W-1:0] r;
        int               j;
        r = p;
        for (int i = NUM_SENSORS; i >= 1; i--) begin
            j = (int'(p) + i) % NUM_SENSORS;
            if (m[j[IDX_W-1:0]]) r = j[IDX_W-1:0];
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        sub_d      = sub_q;
        dist_d     = dist_q;
        trigger_d  = '0;
        valid_d    = valid_q;
        rsensor_d  = rsensor_q;
        rdist_d    = rdist_q;
        rtimeout_d = rtimeout_q;

        case (state_q)
            ST_IDLE: begin
                if (enable && (|sensor_mask)) begin
                    sel_d   = next_idx(ptr_q, sensor_mask);
                    ptr_d   = sel_d;
                    cnt_d   = '0;
                    state_d = ST_TRIGGER;
                end
            end
            ST_TRIGGER: begin
                if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_RISE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_RISE: begin
                if (echo_rise[sel_q]) begin
                    // The rise cycle itself counts as the first echo cycle.
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_MEASURE;
                    if (CYCLES_PER_CM == 1) begin
                        sub_d  = '0;
                        dist_d = 16'd1;
                    end else begin
                        sub_d  = SUB_W'(1);
                        dist_d = '0;
                    end
                end else if (cnt_q >= CNT_W'(ECHO_TIMEOUT_CYCLES - 1)) begin
                    state_d    = ST_PUBLISH;
                    valid_d    = 1'b1;
                    rsensor_d  = sel_q;
                    rdist_d    = DIST_TIMEOUT;
                    rtimeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_MEASURE: begin
                if (echo_fall[sel_q]) begin
                    state_d    = ST_PUBLISH;
                    valid_d    = 1'b1;
                    rsensor_d  = sel_q;
                    rdist_d    = dist_q;
                    rtimeout_d = 1'b0;
                end else if (cnt_q >= CNT_W'(ECHO_TIMEOUT_CYCLES - 1)) begin
                    state_d    = ST_PUBLISH;
                    valid_d    = 1'b1;
                    rsensor_d  = sel_q;
                    rdist_d    = DIST_TIMEOUT;
                    rtimeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (sub_q == SUB_W'(CYCLES_PER_CM - 1)) begin
                        sub_d = '0;
                        if (dist_q != DIST_MAX) dist_d = dist_q + 16'd1;
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                end
            end
            ST_PUBLISH: begin
                if (result_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_TRIGGER) trigger_d[sel_d] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= ST_IDLE;
            ptr_q      <= IDX_W'(NUM_SENSORS - 1);
            sel_q      <= '0;
            cnt_q      <= '0;
            sub_q      <= '0;
            dist_q     <= '0;
            trigger_q  <= '0;
            valid_q    <= 1'b0;
            rsensor_q  <= '0;
            rdist_q    <= '0;
            rtimeout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            sub_q      <= sub_d;
            dist_q     <= dist_d;
            trigger_q  <= trigger_d;
            valid_q    <= valid_d;
            rsensor_q  <= rsensor_d;
            rdist_q    <= rdist_d;
            rtimeout_q <= rtimeout_d;
        end
    end

    assign trigger        = trigger_q;
    assign result_valid   = valid_q;
    assign result_sensor  = rsensor_q;
    assign result_dist_cm = rdist_q;
    assign result_timeout = rtimeout_q;
    assign busy           = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ultra_ping_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ultra_ping_scheduler
// Description : Directed self-checking bench for ultra_ping_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ultra_ping_scheduler;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        enable = 1'b0;
    logic        result_ready = 1'b1;
    logic [3:0]  sensor_mask = 4'b0000;
    logic [3:0]  echo_drv = 4'b0000;
    logic        tog_en = 1'b0;
    logic [1:0]  tcnt = 2'd0;
    logic [3:0]  echo;
    logic [3:0]  trigger;
    logic        result_valid;
    logic [1:0]  result_sensor;
    logic [15:0] result_dist_cm;
    logic        result_timeout;
    logic        busy;

    int n_assert = 0;
    int n_fail = 0;
    int multi_hot = 0;
    int trig2_cnt = 0;

    assign echo = echo_drv | {3'b000, tog_en & tcnt[1]};

    ultra_ping_scheduler #(
        .NUM_SENSORS(4), .TRIG_CYCLES(4), .CYCLES_PER_CM(10),
        .ECHO_TIMEOUT_CYCLES(200), .GUARD_CYCLES(8)
    ) dut (
        .clk(clk), .reset_l(reset_l), .enable(enable), .sensor_mask(sensor_mask),
        .echo(echo), .trigger(trigger), .result_valid(result_valid),
        .result_ready(result_ready), .result_sensor(result_sensor),
        .result_dist_cm(result_dist_cm), .result_timeout(result_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tcnt <= tcnt + 2'd1;

    always @(negedge clk) begin
        if ($countones(trigger) > 1) multi_hot <= multi_hot + 1;
        if (trigger[2]) trig2_cnt <= trig2_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        enable = 1'b0;
        echo_drv = 4'b0000;
        tog_en = 1'b0;
        result_ready = 1'b1;
        repeat (3) tick();
        reset_l = 1'b1;
        tick();
    endtask

    task automatic wait_trig_rise(output int s);
        int n;
        n = 0;
        while (trigger == 4'b0000 && n < 200) begin
            tick();
            n++;
        end
        check("trig_rise_seen", {31'd0, trigger != 4'b0000}, 32'd1);
        s = 0;
        for (int i = 0; i < 4; i++) if (trigger[i]) s = i;
    endtask

    task automatic wait_trig_fall(input int s, output int len);
        len = 0;
        while (trigger[s] && len < 100) begin
            tick();
            len++;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!result_valid && n < 1000) begin
            tick();
            n++;
        end
        check("valid_seen", {31'd0, result_valid}, 32'd1);
    endtask

    initial begin
        int s, len, n, m, bad, m0, t20;
        int exp_seq[4];

        exp_seq = '{0, 1, 3, 0};

        // Reset state
        reset_l = 1'b0;
        tick();
        check("rst_trigger", {28'd0, trigger}, 32'd0);
        check("rst_valid_busy", {30'd0, result_valid, busy}, 32'd0);
        check("rst_payload", {13'd0, result_timeout, result_sensor, result_dist_cm}, 32'd0);
        do_reset();

        // Single ping: 57-cycle echo -> 5 cm
        sensor_mask = 4'b0001;
        enable = 1'b1;
        wait_trig_rise(s);
        check("t1_sel", s, 0);
        wait_trig_fall(s, len);
        check("t1_trig_len", len, 4);
        repeat (5) tick();
        echo_drv[0] = 1'b1;
        repeat (57) tick();
        echo_drv[0] = 1'b0;
        wait_valid(n);
        check("t1_sensor", {30'd0, result_sensor}, 32'd0);
        check("t1_dist", {16'd0, result_dist_cm}, 32'd5);
        check("t1_timeout", {31'd0, result_timeout}, 32'd0);
        tick();
        check("t1_valid_drop", {31'd0, result_valid}, 32'd0);
        enable = 1'b0;

        // Rotation over mask 1011
        do_reset();
        m0 = multi_hot;
        t20 = trig2_cnt;
        sensor_mask = 4'b1011;
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_trig_rise(s);
            check("t2_trig_sensor", s, exp_seq[k]);
            wait_trig_fall(s, len);
            repeat (3) tick();
            echo_drv[s] = 1'b1;
            repeat (30) tick();
            echo_drv[s] = 1'b0;
            wait_valid(n);
            check("t2_result_sensor", {30'd0, result_sensor}, exp_seq[k]);
            check("t2_dist", {16'd0, result_dist_cm}, 32'd3);
        end
        enable = 1'b0;
        check("t2_no_trig2", trig2_cnt - t20, 0);
        check("t2_one_hot", multi_hot - m0, 0);

        // Timeout on sensor 2
        do_reset();
        sensor_mask = 4'b0100;
        enable = 1'b1;
        wait_trig_rise(s);
        check("t3_sel", s, 2);
        wait_trig_fall(s, len);
        wait_valid(n);
        check("t3_latency", n, 200);
        check("t3_payload", {13'd0, result_timeout, result_sensor, result_dist_cm},
              {13'd0, 1'b1, 2'd2, 16'hFFFF});
        m = 0;
        while (trigger == 4'b0000 && m < 100) begin
            tick();
            m++;
        end
        check("t3_reping_delay", m, 10);
        check("t3_reping_trig", {28'd0, trigger}, 32'h4);
        enable = 1'b0;

        // Stale echo on sensor 1 with crosstalk on sensor 0
        do_reset();
        sensor_mask = 4'b0010;
        enable = 1'b1;
        tog_en = 1'b1;
        wait_trig_rise(s);
        check("t4_sel", s, 1);
        tick();
        echo_drv[1] = 1'b1;
        wait_trig_fall(s, len);
        repeat (3) tick();
        echo_drv[1] = 1'b0;
        repeat (4) tick();
        echo_drv[1] = 1'b1;
        repeat (40) tick();
        echo_drv[1] = 1'b0;
        wait_valid(n);
        check("t4_payload", {13'd0, result_timeout, result_sensor, result_dist_cm},
              {13'd0, 1'b0, 2'd1, 16'd4});
        tog_en = 1'b0;
        enable = 1'b0;

        // Backpressure
        do_reset();
        sensor_mask = 4'b0001;
        enable = 1'b1;
        result_ready = 1'b0;
        wait_trig_rise(s);
        wait_trig_fall(s, len);
        repeat (2) tick();
        echo_drv[0] = 1'b1;
        repeat (30) tick();
        echo_drv[0] = 1'b0;
        wait_valid(n);
        check("t5_payload", {13'd0, result_timeout, result_sensor, result_dist_cm},
              {13'd0, 1'b0, 2'd0, 16'd3});
        bad = 0;
        repeat (50) begin
            tick();
            if (!result_valid || result_dist_cm != 16'd3 || result_sensor != 2'd0 ||
                result_timeout || trigger != 4'b0000) bad++;
        end
        check("t5_hold", bad, 0);
        result_ready = 1'b1;
        tick();
        check("t5_valid_drop", {31'd0, result_valid}, 32'd0);
        check("t5_busy_guard", {31'd0, busy}, 32'd1);
        m = 0;
        while (trigger == 4'b0000 && m < 100) begin
            tick();
            m++;
        end
        check("t5_guard_len", m, 9);
        enable = 1'b0;

        // Reset during TRIGGER
        do_reset();
        sensor_mask = 4'b0001;
        enable = 1'b1;
        wait_trig_rise(s);
        tick();
        reset_l = 1'b0;
        #1;
        check("t6_async_trig", {28'd0, trigger}, 32'd0);
        check("t6_async_busy", {31'd0, busy}, 32'd0);
        tick();
        reset_l = 1'b1;
        tick();

        // Enable dropped during MEASURE
        wait_trig_rise(s);
        wait_trig_fall(s, len);
        repeat (2) tick();
        echo_drv[0] = 1'b1;
        repeat (10) tick();
        enable = 1'b0;
        repeat (20) tick();
        echo_drv[0] = 1'b0;
        wait_valid(n);
        check("t7_dist", {16'd0, result_dist_cm}, 32'd3);
        m = 0;
        while (busy && m < 100) begin
            tick();
            m++;
        end
        check("t7_idle_delay", m, 9);
        bad = 0;
        repeat (50) begin
            tick();
            if (trigger != 4'b0000 || busy) bad++;
        end
        check("t7_no_retrigger", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
